// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: registered state sequencer with outputs
// decoded from the state register and the opcode latched in DECODE.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       Illegal,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUOp,
    output logic [3:0] State
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_INC   = 6'h07;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXEC  = 4'd6,  S_RWB    = 4'd7,
        S_IEXEC  = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;

    always_comb begin
        state_d = S_FETCH;
        op_d    = op_q;
        case (state_q)
            S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                op_d = OP;
                case (OP)
                    OP_LW, OP_SW:           state_d = S_MEMADR;
                    OP_RTYPE:               state_d = S_REXEC;
                    OP_ADDI, OP_ORI, OP_INC: state_d = S_IEXEC;
                    OP_BEQ, OP_BNE:         state_d = S_BRANCH;
                    OP_J:                   state_d = S_JUMP;
                    default:                state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = MemReady ? S_FETCH : S_MEMWR;
            S_REXEC:  state_d = S_RWB;
            S_IEXEC:  state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= 6'h00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Illegal is flagged from the live OP because op_q only captures it at the end of DECODE.
    always_comb begin
        PCWrite  = 1'b0; IorD     = 1'b0; MemRead  = 1'b0; MemWrite = 1'b0;
        IRWrite  = 1'b0; RegDst   = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
        ALUSrcA  = 1'b0; Illegal  = 1'b0; ALUSrcB  = 2'b00; PCSource = 2'b00;
        ALUOp    = 3'b000;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = 3'b100;
                IRWrite = MemReady & ~reset;
                PCWrite = MemReady & ~reset;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = 3'b100;
                Illegal = !(OP inside {OP_RTYPE, OP_ADDI, OP_ORI, OP_INC, OP_BEQ,
                                       OP_BNE, OP_LW, OP_SW, OP_J});
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 3'b100;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_REXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b111;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (op_q)
                    OP_ORI:  ALUOp = 3'b101;
                    OP_INC:  ALUOp = 3'b110;
                    default: ALUOp = 3'b100;
                endcase
            end
            S_IWB:    RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 3'b001;
                PCSource = 2'b01;
                PCWrite  = ((op_q == OP_BEQ) & Zero) | ((op_q == OP_BNE) & ~Zero);
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            default: ;
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each task walks one instruction class
// through the sequencer and checks state and control outputs cycle by cycle.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OP;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg;
    logic       RegWrite, ALUSrcA, Illegal;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] State;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .OP(OP), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .Illegal(Illegal), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOp(ALUOp), .State(State)
    );

    // Advance one clock; inputs are then changed at posedge+1 and outputs read at posedge+2.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; MemReady = 1'b1; OP = 6'h00; Zero = 1'b0;
        cyc(); cyc(); #1;
        tests_run++; if (State !== 4'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", State); end
        tests_run++; if (PCWrite !== 1'b0 || IRWrite !== 1'b0) begin tests_failed++; $display("FAIL reset_pcir: got PCWrite=%b IRWrite=%b expected 0 0", PCWrite, IRWrite); end
        reset = 1'b0; #1;
        tests_run++; if (MemRead !== 1'b1 || IRWrite !== 1'b1 || PCWrite !== 1'b1 || ALUSrcB !== 2'b01 || ALUOp !== 3'b100)
            begin tests_failed++; $display("FAIL post_reset_fetch: got MemRead=%b IRWrite=%b PCWrite=%b ALUSrcB=%b ALUOp=%b expected 1 1 1 01 100", MemRead, IRWrite, PCWrite, ALUSrcB, ALUOp); end
    endtask

    task automatic test_rtype();
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        OP = 6'h00; MemReady = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            tests_run++; if (State !== exp_st[i] || RegWrite !== (i == 3) || RegDst !== (i == 3))
                begin tests_failed++; $display("FAIL rtype_step%0d: got State=%0d RegWrite=%b RegDst=%b expected %0d %b %b", i, State, RegWrite, RegDst, exp_st[i], (i == 3), (i == 3)); end
            if (i == 2) begin
                tests_run++; if (ALUOp !== 3'b111 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b00)
                    begin tests_failed++; $display("FAIL rtype_exec: got ALUOp=%b ALUSrcA=%b ALUSrcB=%b expected 111 1 00", ALUOp, ALUSrcA, ALUSrcB); end
            end
            if (i < 4) begin cyc(); #1; end
        end
    endtask

    task automatic test_lw_wait();
        OP = 6'h23; MemReady = 1'b1;
        cyc(); cyc();
        tests_run++; if (State !== 4'd2) begin tests_failed++; $display("FAIL lw_memadr: got %0d expected 2", State); end
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            tests_run++; if (State !== 4'd3 || MemRead !== 1'b1 || IorD !== 1'b1 || MemWrite !== 1'b0)
                begin tests_failed++; $display("FAIL lw_wait%0d: got State=%0d MemRead=%b IorD=%b MemWrite=%b expected 3 1 1 0", i, State, MemRead, IorD, MemWrite); end
        end
        MemReady = 1'b1;
        cyc(); #1;
        tests_run++; if (State !== 4'd4 || MemtoReg !== 1'b1 || RegWrite !== 1'b1 || RegDst !== 1'b0)
            begin tests_failed++; $display("FAIL lw_memwb: got State=%0d MemtoReg=%b RegWrite=%b RegDst=%b expected 4 1 1 0", State, MemtoReg, RegWrite, RegDst); end
        cyc(); #1;
        tests_run++; if (State !== 4'd0) begin tests_failed++; $display("FAIL lw_return: got %0d expected 0", State); end
    endtask

    task automatic test_branch();
        logic [5:0] ops [3] = '{6'h04, 6'h05, 6'h05};
        logic       zs  [3] = '{1'b1, 1'b1, 1'b0};
        logic       pcw [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            OP = ops[i]; Zero = zs[i]; MemReady = 1'b1;
            cyc(); cyc(); #1;
            tests_run++; if (State !== 4'd10 || PCWrite !== pcw[i] || PCSource !== 2'b01 || ALUOp !== 3'b001)
                begin tests_failed++; $display("FAIL branch%0d: got State=%0d PCWrite=%b PCSource=%b ALUOp=%b expected 10 %b 01 001", i, State, PCWrite, PCSource, ALUOp, pcw[i]); end
            cyc(); #1;
            tests_run++; if (State !== 4'd0) begin tests_failed++; $display("FAIL branch%0d_return: got %0d expected 0", i, State); end
        end
        Zero = 1'b0;
    endtask

    task automatic test_jump();
        OP = 6'h02; MemReady = 1'b1;
        cyc(); cyc(); #1;
        tests_run++; if (State !== 4'd11 || PCWrite !== 1'b1 || PCSource !== 2'b10)
            begin tests_failed++; $display("FAIL jump: got State=%0d PCWrite=%b PCSource=%b expected 11 1 10", State, PCWrite, PCSource); end
        cyc(); #1;
        tests_run++; if (State !== 4'd0) begin tests_failed++; $display("FAIL jump_return: got %0d expected 0", State); end
    endtask

    task automatic test_illegal();
        OP = 6'h3f; MemReady = 1'b1;
        cyc(); #1;
        tests_run++; if (State !== 4'd1 || Illegal !== 1'b1 || RegWrite !== 1'b0 || MemWrite !== 1'b0)
            begin tests_failed++; $display("FAIL illegal_decode: got State=%0d Illegal=%b RegWrite=%b MemWrite=%b expected 1 1 0 0", State, Illegal, RegWrite, MemWrite); end
        cyc(); #1;
        tests_run++; if (State !== 4'd0 || Illegal !== 1'b0 || RegWrite !== 1'b0 || MemWrite !== 1'b0)
            begin tests_failed++; $display("FAIL illegal_after: got State=%0d Illegal=%b RegWrite=%b MemWrite=%b expected 0 0 0 0", State, Illegal, RegWrite, MemWrite); end
    endtask

    task automatic test_sw_reset();
        OP = 6'h2b; MemReady = 1'b1;
        cyc(); cyc();
        MemReady = 1'b0;
        cyc(); cyc(); #1;
        tests_run++; if (State !== 4'd5 || MemWrite !== 1'b1 || MemRead !== 1'b0)
            begin tests_failed++; $display("FAIL sw_wait: got State=%0d MemWrite=%b MemRead=%b expected 5 1 0", State, MemWrite, MemRead); end
        reset = 1'b1;
        cyc(); #1;
        tests_run++; if (State !== 4'd0 || MemWrite !== 1'b0)
            begin tests_failed++; $display("FAIL sw_reset: got State=%0d MemWrite=%b expected 0 0", State, MemWrite); end
        reset = 1'b0; MemReady = 1'b1;
    endtask

    task automatic test_iexec();
        logic [5:0] ops [3] = '{6'h0d, 6'h08, 6'h07};
        logic [2:0] aop [3] = '{3'b101, 3'b100, 3'b110};
        for (int i = 0; i < 3; i++) begin
            OP = ops[i]; MemReady = 1'b1;
            cyc(); cyc();
            OP = (i == 0) ? 6'h08 : 6'h0d; #1;
            tests_run++; if (State !== 4'd8 || ALUOp !== aop[i] || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10)
                begin tests_failed++; $display("FAIL iexec%0d: got State=%0d ALUOp=%b ALUSrcA=%b ALUSrcB=%b expected 8 %b 1 10", i, State, ALUOp, ALUSrcA, ALUSrcB, aop[i]); end
            cyc(); #1;
            tests_run++; if (State !== 4'd9 || RegWrite !== 1'b1 || RegDst !== 1'b0 || MemtoReg !== 1'b0)
                begin tests_failed++; $display("FAIL iwb%0d: got State=%0d RegWrite=%b RegDst=%b MemtoReg=%b expected 9 1 0 0", i, State, RegWrite, RegDst, MemtoReg); end
            cyc(); #1;
            tests_run++; if (State !== 4'd0) begin tests_failed++; $display("FAIL iexec%0d_return: got %0d expected 0", i, State); end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch();
        test_jump();
        test_illegal();
        test_sw_reset();
        test_iexec();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
